// File: rtl/kyber_perm_pkg.sv
// Shared constants and types for the Kyber coefficient-index permutation sequencer.
package kyber_perm_pkg;

  localparam int DATA_WIDTH = 5;
  localparam int ADDR_WIDTH = 7;
  localparam int STAGE_BITS = 2;
  localparam int OFFS_BITS  = 5;
  localparam int STAGE_LEN  = 32;
  localparam int NUM_STAGES = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STAGE_BITS-1:0] stage;
    logic                  last;
  } buf_entry_t;

endpackage

// File: rtl/perm_skid_buf.sv
// Two-entry FIFO that absorbs the one-cycle ROM read latency under consumer backpressure.
module perm_skid_buf
  import kyber_perm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       push,
  input  buf_entry_t push_entry,
  input  logic       pop,
  output buf_entry_t head,
  output logic [1:0] occ
);

  buf_entry_t mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (occ != 2'd0);
  assign do_push = push && ((occ != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: the storage is reset as well so the head fields read 0 out of reset; with only two entries this is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else if (clear) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (do_push && !do_pop) begin
        occ <= occ + 2'd1;
      end else if (do_pop && !do_push) begin
        occ <= occ - 2'd1;
      end
    end
  end

endmodule

// File: rtl/perm_seq_ctrl.sv
// Walks a stage range of the permutation ROM and streams tagged indices downstream.
// Optional PERM_SEQ_STALL_CNT_EN adds a saturating stall_cnt output.
module perm_seq_ctrl
  import kyber_perm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [STAGE_BITS-1:0] stage_first,
  input  logic [STAGE_BITS-1:0] stage_last,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] idx_data,
  output logic [STAGE_BITS-1:0] idx_stage,
  output logic                  idx_last,
  output logic                  idx_valid,
  input  logic                  idx_ready,
  output logic                  busy,
  output logic                  done
`ifdef PERM_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  state_t                state;
  state_t                state_nxt;
  logic [STAGE_BITS-1:0] cur_stage;
  logic [STAGE_BITS-1:0] end_stage;
  logic [OFFS_BITS-1:0]  offset;
  logic                  inflight;
  logic [STAGE_BITS-1:0] inflight_stage;
  logic                  inflight_last;
  logic [1:0]            occ;
  buf_entry_t            head;
  buf_entry_t            push_entry;
  logic                  accept;
  logic                  kill;
  logic                  pop;
  logic                  room;
  logic                  issue;
  logic                  issue_last;
  logic                  offset_wrap;

  assign accept      = (state == IDLE) && start;
  assign kill        = abort && (state != IDLE);
  assign pop         = idx_valid && idx_ready;
  assign room        = ({1'b0, occ} + {2'b00, inflight}) < 3'd2;
  assign issue       = (state == RUN) && !abort && (room || pop);
  assign offset_wrap = (offset == OFFS_BITS'(STAGE_LEN - 1));
  assign issue_last  = (cur_stage == end_stage) && offset_wrap;

  assign rom_addr  = {cur_stage, offset};
  assign idx_valid = (occ != 2'd0);
  assign idx_data  = head.data;
  assign idx_stage = head.stage;
  assign idx_last  = head.last;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue && issue_last) state_nxt = DRAIN;
      DRAIN:   if ((occ == 2'd0) && !inflight) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cur_stage      <= '0;
      end_stage      <= '0;
      offset         <= '0;
      inflight       <= 1'b0;
      inflight_stage <= '0;
      inflight_last  <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (issue) begin
        inflight_stage <= cur_stage;
        inflight_last  <= issue_last;
      end
      if (accept) begin
        cur_stage <= stage_first;
        end_stage <= stage_last;
        offset    <= '0;
      end else if (issue) begin
        offset <= offset + 1'b1;
        if (offset_wrap) cur_stage <= cur_stage + 1'b1;
      end
    end
  end

  // The ROM word for last cycle's issue arrives now and is tagged with that issue's stage/last.
  assign push_entry = '{data: rom_data, stage: inflight_stage, last: inflight_last};

  perm_skid_buf u_skid_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (kill),
    .push       (inflight),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .occ        (occ)
  );

`ifdef PERM_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if (idx_valid && !idx_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_perm_seq_ctrl.sv
// Self-checking bench for perm_seq_ctrl: ROM model, queue-based golden sequence, random backpressure.
module tb_perm_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] stage_first = 2'd0;
  logic [1:0] stage_last = 2'd0;
  logic [6:0] rom_addr;
  logic [4:0] rom_data = 5'd0;
  logic [4:0] idx_data;
  logic [1:0] idx_stage;
  logic       idx_last;
  logic       idx_valid;
  logic       idx_ready = 1'b0;
  logic       busy;
  logic       done;
`ifdef PERM_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  perm_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .stage_first (stage_first),
    .stage_last  (stage_last),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .idx_data    (idx_data),
    .idx_stage   (idx_stage),
    .idx_last    (idx_last),
    .idx_valid   (idx_valid),
    .idx_ready   (idx_ready),
    .busy        (busy),
    .done        (done)
`ifdef PERM_SEQ_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // ROM contents: stage 0 is a 4x8 transpose, stage 1 interleaves within groups of 8, stages 2/3 identity.
  function automatic logic [4:0] rom_fn(input int s, input int o);
    case (s)
      0:       return 5'((o % 4) * 8 + o / 4);
      1:       return 5'((o / 8) * 8 + (o % 4) * 2 + (o / 4) % 2);
      default: return 5'(o);
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_fn(int'(rom_addr[6:5]), int'(rom_addr[4:0]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_walk(input int first, input int last, input int ready_pct,
                          input bit check_time, input bit poke);
    int         exp_q[$];
    int         s, nst, n, done_at, hs, stalls, e;
    bit         finished, held;
    logic [8:0] cur, held_v;
    s = first;
    nst = 0;
    do begin
      for (int o = 0; o < 32; o++)
        exp_q.push_back(int'(rom_fn(s, o)) * 8 + s * 2 + ((s == last && o == 31) ? 1 : 0));
      nst++;
      finished = (s == last);
      s = (s + 1) % 4;
    end while (!finished);

    @(negedge clk);
    stage_first = 2'(first);
    stage_last  = 2'(last);
    start       = 1'b1;
    idx_ready   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    n = 0; done_at = -1; hs = 0; stalls = 0; held = 1'b0;
    while (done_at < 0 && n < 4000) begin
      idx_ready = ($urandom_range(99) < ready_pct);
      if (poke && n == 20) begin
        start = 1'b1;
        stage_first = 2'(first + 1);
        stage_last  = 2'(first + 1);
      end else begin
        start = 1'b0;
      end
      cur = {idx_valid, idx_data, idx_stage, idx_last};
      if (held) check("stall_stable", cur, held_v);
      held = idx_valid && !idx_ready;
      if (held) begin
        held_v = cur;
        stalls++;
      end
      if (idx_valid && idx_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_index", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("index", {idx_data, idx_stage, idx_last}, e);
        end
        hs++;
      end
      @(negedge clk);
      n++;
      if (done) done_at = n;
    end
    start = 1'b0;
    check("done_seen", done_at >= 0, 1);
    check("handshakes", hs, 32 * nst);
    if (check_time) check("done_latency", done_at, 32 * nst + 3);
`ifdef PERM_SEQ_STALL_CNT_EN
    check("stall_cnt", stall_cnt, stalls);
`endif
    @(negedge clk);
    check("done_pulse_idle", {done, busy}, 0);
  endtask

  task automatic run_abort();
    int n, hs;
    bit seen_done;
    @(negedge clk);
    stage_first = 2'd0;
    stage_last  = 2'd3;
    start       = 1'b1;
    idx_ready   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; hs = 0;
    while (hs < 10 && n < 200) begin
      if (idx_valid) hs++;
      @(negedge clk);
      n++;
    end
    check("abort_setup", hs, 10);
    idx_ready = 1'b0;
    abort     = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_outputs", {idx_valid, busy, done}, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen_done |= done | busy | idx_valid;
    end
    check("abort_quiet", seen_done, 0);
  endtask

  task automatic run_reset_mid();
    @(negedge clk);
    stage_first = 2'd1;
    stage_last  = 2'd2;
    start       = 1'b1;
    idx_ready   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("busy_before_reset", {busy, idx_valid}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_outputs",
          {rom_addr, idx_data, idx_stage, idx_last, idx_valid, busy, done}, 0);
`ifdef PERM_SEQ_STALL_CNT_EN
    check("reset_mid_stall_cnt", stall_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", {rom_addr, idx_data, idx_stage, idx_last, idx_valid, busy, done}, 0);
`ifdef PERM_SEQ_STALL_CNT_EN
    check("reset_stall_cnt", stall_cnt, 0);
`endif
    rst_n = 1'b1;

    run_walk(0, 0, 100, 1'b1, 1'b0);
    run_walk(1, 1, 100, 1'b1, 1'b0);
    run_walk(2, 3, 100, 1'b1, 1'b0);
    run_walk(3, 0, 100, 1'b1, 1'b0);
    run_walk(0, 3, 50, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      run_walk(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(20, 90)),
               1'b0, 1'b0);
    run_abort();
    run_walk(0, 3, 100, 1'b1, 1'b0);
    run_reset_mid();
    run_walk(1, 2, 100, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
